// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
//   Shared types for the cache-control slice.
//   fence_state_t   : sequencer state encoding
//   fence_pending_t : request bits latched when a fence sequence starts
//   next_stage()    : stage ordering DFLUSH -> ICLEAR -> TLB -> COMPLETE,
//                     skipping every stage that is not required
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DFLUSH   = 3'd1,
        ICLEAR   = 3'd2,
        TLB      = 3'd3,
        COMPLETE = 3'd4
    } fence_state_t;

    typedef struct packed {
        logic fence;
        logic fence_i;
        logic sfence;
    } fence_pending_t;

    // First stage still required after leaving 'from'.
    function automatic fence_state_t next_stage(input fence_state_t from,
                                                input fence_pending_t p);
        logic need_d;
        logic need_i;
        logic need_t;
        fence_state_t s;
        need_d = (from == IDLE) && (p.fence || p.fence_i);
        need_i = ((from == IDLE) || (from == DFLUSH)) && p.fence_i;
        need_t = ((from == IDLE) || (from == DFLUSH) || (from == ICLEAR)) && p.sfence;
        if (need_d)      s = DFLUSH;
        else if (need_i) s = ICLEAR;
        else if (need_t) s = TLB;
        else             s = COMPLETE;
        return s;
    endfunction

endpackage

// File: rtl/fence_timeout_counter.sv
// ---------------------------------------------------------------------------
// fence_timeout_counter
//   Per-stage watchdog for the fence sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count at 0 on the next edge (stage entry)
//   enable   : count one stage cycle
//   expired  : count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module fence_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cache_fence_sequencer.sv
// ---------------------------------------------------------------------------
// cache_fence_sequencer
//   Serialises FENCE / FENCE.I / SFENCE.VMA into cache and TLB maintenance
//   commands and returns a single completion pulse to the pipeline.
//   CLK, RST                      : clock, synchronous active-high reset
//   fence_req/fence_i_req/sfence_req : held requests from the pipeline
//   *_done                        : completion strobes from caches/TLBs
//   dcache_flush/icache_clear/itlb_fence/dtlb_fence : level commands
//   icache_flush/dcache_clear     : unused commands, tied low
//   busy                          : sequence in progress
//   fence_done/fence_err          : one-cycle completion pulse and its error
// All outputs are registered from the next-state values.
// ---------------------------------------------------------------------------
module cache_fence_sequencer
    import cache_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic fence_req,
    input  logic fence_i_req,
    input  logic sfence_req,
    input  logic dflush_done,
    input  logic iclear_done,
    input  logic itlb_fence_done,
    input  logic dtlb_fence_done,
    output logic dcache_flush,
    output logic icache_clear,
    output logic itlb_fence,
    output logic dtlb_fence,
    output logic icache_flush,
    output logic dcache_clear,
    output logic busy,
    output logic fence_done,
    output logic fence_err
);

    fence_state_t   state, state_n;
    fence_pending_t pending, pending_n;
    logic           itlb_seen, itlb_seen_n;
    logic           dtlb_seen, dtlb_seen_n;
    logic           err, err_n;
    logic           expired;
    logic           abort;
    logic           stage_active;

    assign stage_active = (state == DFLUSH) || (state == ICLEAR) || (state == TLB);

    fence_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK),
        .rst    (RST),
        .clear  (state_n != state),
        .enable (stage_active),
        .expired(expired)
    );

    always_comb begin
        state_n     = state;
        pending_n   = pending;
        itlb_seen_n = itlb_seen;
        dtlb_seen_n = dtlb_seen;
        err_n       = err;
        abort       = 1'b0;

        case (state)
            IDLE: begin
                if (fence_req || fence_i_req || sfence_req) begin
                    pending_n.fence   = fence_req;
                    pending_n.fence_i = fence_i_req;
                    pending_n.sfence  = sfence_req;
                    state_n           = next_stage(IDLE, pending_n);
                end
            end
            DFLUSH: begin
                if (dflush_done)  state_n = next_stage(DFLUSH, pending);
                else if (expired) abort   = 1'b1;
            end
            ICLEAR: begin
                if (iclear_done)  state_n = next_stage(ICLEAR, pending);
                else if (expired) abort   = 1'b1;
            end
            TLB: begin
                // A done seen this cycle counts immediately, so the command
                // drops on the very next edge.
                itlb_seen_n = itlb_seen | itlb_fence_done;
                dtlb_seen_n = dtlb_seen | dtlb_fence_done;
                if (itlb_seen_n && dtlb_seen_n) state_n = COMPLETE;
                else if (expired)               abort   = 1'b1;
            end
            COMPLETE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort) begin
            state_n = COMPLETE;
            err_n   = 1'b1;
        end
        if (state_n == IDLE) begin
            err_n = 1'b0;
        end
        if (state_n != TLB) begin
            itlb_seen_n = 1'b0;
            dtlb_seen_n = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            pending      <= '0;
            itlb_seen    <= 1'b0;
            dtlb_seen    <= 1'b0;
            err          <= 1'b0;
            dcache_flush <= 1'b0;
            icache_clear <= 1'b0;
            itlb_fence   <= 1'b0;
            dtlb_fence   <= 1'b0;
            busy         <= 1'b0;
            fence_done   <= 1'b0;
            fence_err    <= 1'b0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            itlb_seen    <= itlb_seen_n;
            dtlb_seen    <= dtlb_seen_n;
            err          <= err_n;
            dcache_flush <= (state_n == DFLUSH);
            icache_clear <= (state_n == ICLEAR);
            itlb_fence   <= (state_n == TLB) && !itlb_seen_n;
            dtlb_fence   <= (state_n == TLB) && !dtlb_seen_n;
            busy         <= (state_n != IDLE);
            fence_done   <= (state_n == COMPLETE);
            fence_err    <= (state_n == COMPLETE) && err_n;
        end
    end

    assign icache_flush = 1'b0;
    assign dcache_clear = 1'b0;

endmodule

// File: tb/tb_cache_fence_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cache_fence_sequencer
//   Directed scenarios for cache_fence_sequencer (TIMEOUT_CYCLES = 8).
//   Expected output vectors are queued as stimulus is driven and compared
//   one cycle later against the DUT outputs.
//   Vector layout: {dcache_flush, icache_clear, itlb_fence, dtlb_fence,
//                   busy, fence_done, fence_err, icache_flush, dcache_clear}
// ---------------------------------------------------------------------------
module tb_cache_fence_sequencer;

    logic CLK = 1'b0;
    logic RST;
    logic fence_req, fence_i_req, sfence_req;
    logic dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done;
    logic dcache_flush, icache_clear, itlb_fence, dtlb_fence;
    logic icache_flush, dcache_clear, busy, fence_done, fence_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        string      name;
        logic [2:0] req;      // {fence, fence_i, sfence}
        int         df_at, ic_at, it_at, dt_at;
        int         df_lo, df_hi, ic_lo, ic_hi, it_lo, it_hi, dt_lo, dt_hi;
        int         done_at;
        logic       err;
    } scen_t;

    scen_t scens[9];

    always #5 CLK = ~CLK;

    cache_fence_sequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .fence_req      (fence_req),
        .fence_i_req    (fence_i_req),
        .sfence_req     (sfence_req),
        .dflush_done    (dflush_done),
        .iclear_done    (iclear_done),
        .itlb_fence_done(itlb_fence_done),
        .dtlb_fence_done(dtlb_fence_done),
        .dcache_flush   (dcache_flush),
        .icache_clear   (icache_clear),
        .itlb_fence     (itlb_fence),
        .dtlb_fence     (dtlb_fence),
        .icache_flush   (icache_flush),
        .dcache_clear   (dcache_clear),
        .busy           (busy),
        .fence_done     (fence_done),
        .fence_err      (fence_err)
    );

    function automatic logic [8:0] mk(input bit df, input bit ic, input bit it, input bit dt,
                                      input bit bz, input bit dn, input bit er);
        return {df, ic, it, dt, bz, dn, er, 2'b00};
    endfunction

    function automatic logic [8:0] exp_at(input scen_t s, input int k);
        return mk(k >= s.df_lo && k <= s.df_hi,
                  k >= s.ic_lo && k <= s.ic_hi,
                  k >= s.it_lo && k <= s.it_hi,
                  k >= s.dt_lo && k <= s.dt_hi,
                  k >= 1 && k <= s.done_at,
                  k == s.done_at,
                  s.err && (k == s.done_at));
    endfunction

    task automatic check_vec(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [8:0] exp;
        exp = exp_q.pop_front();
        check_vec(tag, {dcache_flush, icache_clear, itlb_fence, dtlb_fence,
                        busy, fence_done, fence_err, icache_flush, dcache_clear}, exp);
    endtask

    task automatic run_scen(input scen_t s);
        exp_q.push_back(exp_at(s, 0));
        compare_out($sformatf("%s c0", s.name));
        for (int k = 0; k <= s.done_at + 1; k++) begin
            // Pipeline holds requests until it sees fence_done, then drops them.
            fence_req       = (k <= s.done_at) && s.req[2];
            fence_i_req     = (k <= s.done_at) && s.req[1];
            sfence_req      = (k <= s.done_at) && s.req[0];
            dflush_done     = (k == s.df_at);
            iclear_done     = (k == s.ic_at);
            itlb_fence_done = (k == s.it_at);
            dtlb_fence_done = (k == s.dt_at);
            exp_q.push_back(exp_at(s, k + 1));
            @(posedge CLK);
            #1;
            compare_out($sformatf("%s c%0d", s.name, k + 1));
        end
        {fence_req, fence_i_req, sfence_req} = 3'b000;
        {dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done} = 4'b0000;
    endtask

    task automatic run_reset_case();
        logic [8:0] rexp[0:10];
        rexp[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        rexp[1]  = mk(1, 0, 0, 0, 1, 0, 0);
        rexp[2]  = mk(1, 0, 0, 0, 1, 0, 0);
        rexp[3]  = mk(1, 0, 0, 0, 1, 0, 0);
        rexp[4]  = mk(0, 0, 0, 0, 0, 0, 0);
        rexp[5]  = mk(1, 0, 0, 0, 1, 0, 0);
        rexp[6]  = mk(0, 1, 0, 0, 1, 0, 0);
        rexp[7]  = mk(0, 0, 1, 1, 1, 0, 0);
        rexp[8]  = mk(0, 0, 0, 0, 1, 1, 0);
        rexp[9]  = mk(0, 0, 0, 0, 0, 0, 0);
        rexp[10] = mk(0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(rexp[0]);
        compare_out("rst_mid c0");
        for (int k = 0; k <= 9; k++) begin
            RST             = (k == 3);
            fence_req       = 1'b0;
            fence_i_req     = (k <= 8);
            sfence_req      = (k <= 8);
            dflush_done     = (k == 5);
            iclear_done     = (k == 6);
            itlb_fence_done = (k == 7);
            dtlb_fence_done = (k == 7);
            exp_q.push_back(rexp[k + 1]);
            @(posedge CLK);
            #1;
            compare_out($sformatf("rst_mid c%0d", k + 1));
        end
        RST = 1'b0;
        {fence_req, fence_i_req, sfence_req} = 3'b000;
        {dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done} = 4'b0000;
    endtask

    initial begin
        scens[0] = '{"fence",        3'b100,  4, -1,  2, -1, 1, 4, 1, 0,  1, 0, 1, 0,  5, 1'b0};
        scens[1] = '{"min_lat",      3'b100,  1, -1, -1, -1, 1, 1, 1, 0,  1, 0, 1, 0,  2, 1'b0};
        scens[2] = '{"fence_i",      3'b010,  3,  6, -1, -1, 1, 3, 4, 6,  1, 0, 1, 0,  7, 1'b0};
        scens[3] = '{"sfence",       3'b001, -1, -1,  5,  2, 1, 0, 1, 0,  1, 5, 1, 2,  6, 1'b0};
        scens[4] = '{"fence_to",     3'b100, -1, -1, -1, -1, 1, 8, 1, 0,  1, 0, 1, 0,  9, 1'b1};
        scens[5] = '{"merge",        3'b101,  1, -1,  3,  3, 1, 1, 1, 0,  2, 3, 2, 3,  4, 1'b0};
        scens[6] = '{"iclear_early", 3'b010,  2,  2, -1, -1, 1, 2, 3, 10, 1, 0, 1, 0, 11, 1'b1};
        scens[7] = '{"tlb_to",       3'b001, -1, -1, -1,  2, 1, 0, 1, 0,  1, 8, 1, 2,  9, 1'b1};
        scens[8] = '{"all3",         3'b111,  1,  2,  3,  4, 1, 1, 2, 2,  3, 3, 3, 4,  5, 1'b0};

        RST = 1'b1;
        {fence_req, fence_i_req, sfence_req} = 3'b000;
        {dflush_done, iclear_done, itlb_fence_done, dtlb_fence_done} = 4'b0000;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        compare_out("reset");

        for (int i = 0; i < 9; i++) begin
            run_scen(scens[i]);
        end
        run_reset_case();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_fence_sequencer.md
CACHE_FENCE_SEQUENCER -- requirements
Module: cache_fence_sequencer

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles a stage may wait for its done before aborting (legal range 2..65535).
REQ-002 The module SHALL have these ports, one per line:
- CLK  input  1  clock; one clock, rising edge only.
- RST  input  1  reset; synchronous, active-high.
- fence_req  input  1  FENCE: write back the data cache.
- fence_i_req  input  1  FENCE.I: write back the data cache, then clear the instruction cache.
- sfence_req  input  1  SFENCE.VMA: fence both TLBs.
- dflush_done  input  1  data-cache flush complete.
- iclear_done  input  1  instruction-cache clear complete.
- itlb_fence_done  input  1  instruction-TLB fence complete.
- dtlb_fence_done  input  1  data-TLB fence complete.
- dcache_flush  output  1  data-cache flush command (level).
- icache_clear  output  1  instruction-cache clear command (level).
- itlb_fence  output  1  instruction-TLB fence command (level).
- dtlb_fence  output  1  data-TLB fence command (level).
- icache_flush, dcache_clear  output  1  each; tied 0.
- busy  output  1  a sequence is in progress.
- fence_done  output  1  one-cycle completion pulse to the pipeline.
- fence_err  output  1  valid with fence_done: at least one stage timed out.

Function
REQ-003 All outputs SHALL be registered, so state and outputs change only at the CLK edge.
REQ-004 States SHALL be IDLE, DFLUSH, ICLEAR, TLB, COMPLETE.
REQ-005 Request handshake: the pipeline holds its request(s) high until it sees fence_done, then drops them the next cycle.
REQ-006 In IDLE, when any request is high, the module SHALL latch {fence, fence_i, sfence} into pending bits and leave IDLE the next cycle.
REQ-007 Requests seen outside IDLE SHALL be ignored.
REQ-008 Stage order SHALL be DFLUSH (if fence or fence_i pending), then ICLEAR (if fence_i pending), then TLB (if sfence pending), then COMPLETE.
REQ-009 Stages whose pending bit is clear SHALL be skipped with zero cycles spent in them.
REQ-010 A stage's command output SHALL be high during every cycle the module is in that stage: DFLUSH drives dcache_flush, ICLEAR drives icache_clear, TLB drives itlb_fence and dtlb_fence together.
REQ-011 When a stage's done input is sampled high, that stage's command SHALL drop on the next edge and the next stage's command SHALL rise on that same edge.
REQ-012 In TLB, each done SHALL be captured in a sticky bit; the module leaves TLB only once both are captured.
REQ-013 Each TLB command SHALL drop individually once its own done is captured.
REQ-014 A done input asserted while its stage is not active SHALL be ignored.
REQ-015 busy SHALL be high in every state except IDLE.
REQ-016 COMPLETE SHALL last exactly 1 cycle, with fence_done=1 for that cycle; the next state SHALL be IDLE.
REQ-017 Because COMPLETE always returns to IDLE, the earliest next request sample is one cycle after fence_done, so a request dropped per REQ-005 never re-triggers.
REQ-018 Timeout counter:
- clears to 0 on every stage entry and increments each stage cycle;
- if it reaches TIMEOUT_CYCLES-1 with the stage done still missing, the module SHALL drop all commands, set the err flag, and go to COMPLETE.
REQ-019 fence_err SHALL equal the err flag during COMPLETE and be 0 otherwise; the err flag clears on IDLE entry.
REQ-020 Minimum latency (fence only, dflush_done high in the first DFLUSH cycle): request sampled at cycle 0, fence_done at cycle 2.
REQ-021 When several requests are sampled in the same cycle, they SHALL merge into one sequence that ends in one fence_done.

Reset
REQ-022 While RST is high at a CLK edge, the module SHALL, on that edge, go to IDLE and clear all outputs, pending bits, sticky bits, the counter and the err flag to 0.
REQ-023 This SHALL hold in any state, including mid-sequence; the aborted operation produces no fence_done.
REQ-024 After RST falls, the first request sample SHALL occur at the first edge with RST low.

Structure
REQ-025 fence_state_t (the state enum) and fence_pending_t (packed struct of the 3 pending bits) SHALL live in shared package cache_ctrl_pkg.
REQ-026 The timeout counter SHALL be a separate sub-module, fence_timeout_counter, with inputs clear and enable, output expired, and parameter TIMEOUT_CYCLES.
REQ-027 The command/done ports SHALL connect directly to the pipeline side of the existing cache-control interface.

Verification
REQ-028 fence_req=1 at cycle 0, dflush_done=1 at cycle 4 -> dcache_flush=1 over cycles 1-4, fence_done=1 at cycle 5 only, fence_err=0.
REQ-029 fence_i_req, dflush_done at cycle 3, iclear_done at cycle 6 -> dcache_flush over 1-3, icache_clear over 4-6, fence_done at cycle 7.
REQ-030 sfence_req, dtlb_fence_done at cycle 2, itlb_fence_done at cycle 5 -> dtlb_fence drops at cycle 3, itlb_fence drops at cycle 6, fence_done at cycle 6, dcache_flush never high.
REQ-031 TIMEOUT_CYCLES=8, fence_req, dflush_done never asserted -> dcache_flush high over cycles 1-8, fence_done=1 and fence_err=1 at cycle 9.
REQ-032 fence_i_req and sfence_req both at cycle 0; RST=1 at cycle 3 during DFLUSH -> all outputs 0 from cycle 4, no fence_done; requests still held after RST falls start a new sequence.
